// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: registered-select bus source multiplexer with a configurable
// output pipeline, stall, valid flag and sticky illegal-select detection.
module bus_mux_pipe #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned IR_WIDTH  = 8,
  parameter int unsigned NUM_SRC   = 9,
  parameter int unsigned IR_IDX    = 2,
  parameter int unsigned SEL_WIDTH = 4,
  parameter int unsigned IDLE_SEL  = 9,
  parameter int unsigned STAGES    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_WIDTH-1:0]     sel_in,
  input  logic                     sel_valid,
  input  logic                     hold,
  input  logic                     clear_err,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [SEL_WIDTH-1:0]     cur_sel,
  output logic [WIDTH-1:0]         busOut,
  output logic                     busOut_vld,
  output logic                     sel_err
);

  localparam logic [SEL_WIDTH-1:0] LP_IDLE    = SEL_WIDTH'(IDLE_SEL);
  localparam logic [SEL_WIDTH-1:0] LP_NUM     = SEL_WIDTH'(NUM_SRC);
  localparam logic [WIDTH-1:0]     LP_IR_MASK = WIDTH'({IR_WIDTH{1'b1}});

  logic [SEL_WIDTH-1:0] r_cur_sel;
  logic                 r_sel_err;
  logic [WIDTH-1:0]     r_data [STAGES];
  logic                 r_vld  [STAGES];

  logic                 w_sel_legal;
  logic [WIDTH-1:0]     w_mux_data;
  logic                 w_mux_vld;

  assign w_sel_legal = (sel_in < LP_NUM) || (sel_in == LP_IDLE);

  // Source mux from the latched select; the IR channel is zero-extended,
  // idle or any unmatched code drives zero with the valid flag low.
  always_comb begin
    w_mux_data = '0;
    w_mux_vld  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_cur_sel == SEL_WIDTH'(i)) begin
        w_mux_vld = 1'b1;
        if (i == IR_IDX) begin
          w_mux_data = src_data[i*WIDTH +: WIDTH] & LP_IR_MASK;
        end else begin
          w_mux_data = src_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Select register: sticky unless a new select is offered; illegal codes fall back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_sel <= LP_IDLE;
    end else if (!hold && sel_valid) begin
      r_cur_sel <= w_sel_legal ? sel_in : LP_IDLE;
    end
  end

  // Sticky error flag: setting wins over clearing; clearing still works while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (!hold && sel_valid && !w_sel_legal) begin
      r_sel_err <= 1'b1;
    end else if (clear_err) begin
      r_sel_err <= 1'b0;
    end
  end

  // Output pipeline: whole chain advances together, or freezes together under hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
        r_vld[k]  <= 1'b0;
      end
    end else if (!hold) begin
      r_data[0] <= w_mux_data;
      r_vld[0]  <= w_mux_vld;
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_data[k] <= r_data[k-1];
        r_vld[k]  <= r_vld[k-1];
      end
    end
  end

  assign cur_sel    = r_cur_sel;
  assign sel_err    = r_sel_err;
  assign busOut     = r_data[STAGES-1];
  assign busOut_vld = r_vld[STAGES-1];

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Testbench for bus_mux_pipe with STAGES=2: vector table plus hand sequences
// for IR zero-extension and mid-flight reset.
module tb_bus_mux_pipe;

  logic          clk;
  logic          rst;
  logic [3:0]    sel_in;
  logic          sel_valid;
  logic          hold;
  logic          clear_err;
  logic [107:0]  src_data;
  logic [3:0]    cur_sel;
  logic [11:0]   busOut;
  logic          busOut_vld;
  logic          sel_err;

  int n_vec;
  int n_miscmp;

  bus_mux_pipe #(
    .WIDTH(12), .IR_WIDTH(8), .NUM_SRC(9), .IR_IDX(2),
    .SEL_WIDTH(4), .IDLE_SEL(9), .STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .sel_valid(sel_valid),
    .hold(hold), .clear_err(clear_err), .src_data(src_data),
    .cur_sel(cur_sel), .busOut(busOut), .busOut_vld(busOut_vld),
    .sel_err(sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  sel;
    logic        v;
    logic        h;
    logic        c;
    logic [11:0] bus;
    logic        bvld;
    logic [3:0]  cur;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] s, input logic v, input logic h,
                              input logic c, input logic [11:0] b, input logic bv,
                              input logic [3:0] cs, input logic e);
    vec_t r;
    r.sel = s; r.v = v; r.h = h; r.c = c;
    r.bus = b; r.bvld = bv; r.cur = cs; r.err = e;
    return r;
  endfunction

  task automatic check(input string nm, input logic [11:0] eb, input logic ev,
                       input logic [3:0] ec, input logic ee);
    n_vec++;
    if (busOut !== eb) begin
      n_miscmp++;
      $display("FAIL %s busOut: got %h expected %h", nm, busOut, eb);
    end
    if (busOut_vld !== ev) begin
      n_miscmp++;
      $display("FAIL %s busOut_vld: got %b expected %b", nm, busOut_vld, ev);
    end
    if (cur_sel !== ec) begin
      n_miscmp++;
      $display("FAIL %s cur_sel: got %0d expected %0d", nm, cur_sel, ec);
    end
    if (sel_err !== ee) begin
      n_miscmp++;
      $display("FAIL %s sel_err: got %b expected %b", nm, sel_err, ee);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic step(input logic [3:0] s, input logic v, input logic h, input logic c);
    sel_in    = s;
    sel_valid = v;
    hold      = h;
    clear_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_src();
    for (int i = 0; i < 9; i++) src_data[i*12 +: 12] = 12'(10 + i);
  endtask

  initial begin
    n_vec = 0;
    n_miscmp = 0;
    rst = 1'b1;
    sel_in = '0; sel_valid = 1'b0; hold = 1'b0; clear_err = 1'b0;
    src_data = '0;
    set_default_src();

    // Reset state before any clock edge.
    #2;
    check("reset_initial", 12'd0, 1'b0, 4'd9, 1'b0);
    rst = 1'b0;

    //              sel  v  h  c   bus   bv  cur  err
    vecs.push_back(mk(0, 1, 0, 0, 12'd0,  0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 12'd0,  0, 1, 0));
    vecs.push_back(mk(2, 1, 0, 0, 12'd10, 1, 2, 0));
    vecs.push_back(mk(3, 1, 0, 0, 12'd11, 1, 3, 0));
    vecs.push_back(mk(4, 1, 0, 0, 12'd12, 1, 4, 0));
    vecs.push_back(mk(5, 1, 0, 0, 12'd13, 1, 5, 0));
    vecs.push_back(mk(6, 1, 0, 0, 12'd14, 1, 6, 0));
    vecs.push_back(mk(7, 1, 0, 0, 12'd15, 1, 7, 0));
    vecs.push_back(mk(8, 1, 0, 0, 12'd16, 1, 8, 0));
    vecs.push_back(mk(3, 0, 0, 0, 12'd17, 1, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'd18, 1, 8, 0));
    vecs.push_back(mk(12,1, 0, 0, 12'd18, 1, 9, 1));
    vecs.push_back(mk(13,1, 0, 1, 12'd18, 1, 9, 1));
    vecs.push_back(mk(0, 1, 1, 1, 12'd18, 1, 9, 0));
    vecs.push_back(mk(4, 1, 0, 0, 12'd0,  0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'd0,  0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'd14, 1, 4, 0));
    vecs.push_back(mk(6, 1, 1, 0, 12'd14, 1, 4, 0));
    vecs.push_back(mk(12,1, 1, 0, 12'd14, 1, 4, 0));
    vecs.push_back(mk(6, 1, 1, 0, 12'd14, 1, 4, 0));
    vecs.push_back(mk(6, 0, 0, 0, 12'd14, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'd14, 1, 4, 0));
    vecs.push_back(mk(1, 1, 0, 0, 12'd14, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 12'd14, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'd14, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'd11, 1, 1, 0));
    vecs.push_back(mk(9, 1, 0, 0, 12'd11, 1, 9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'd11, 1, 9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'd0,  0, 9, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sel, vecs[i].v, vecs[i].h, vecs[i].c);
      check($sformatf("vec%0d", i), vecs[i].bus, vecs[i].bvld, vecs[i].cur, vecs[i].err);
    end

    // IR channel: upper bits of the source are dropped.
    src_data[2*12 +: 12] = 12'hF12;
    step(2, 1, 0, 0);
    check("ir_accept", 12'd0, 1'b0, 4'd2, 1'b0);
    step(0, 0, 0, 0);
    check("ir_stage1", 12'd0, 1'b0, 4'd2, 1'b0);
    step(0, 0, 0, 0);
    check("ir_zext", 12'h012, 1'b1, 4'd2, 1'b0);
    set_default_src();

    // Reset while a select is in flight: nothing from it may appear.
    step(5, 1, 0, 0);
    check("rst_pre", 12'h012, 1'b1, 4'd5, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", 12'd0, 1'b0, 4'd9, 1'b0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(5, 0, 0, 0);
      check($sformatf("rst_quiet%0d", i), 12'd0, 1'b0, 4'd9, 1'b0);
    end
    step(5, 1, 0, 0);
    check("rst_resel", 12'd0, 1'b0, 4'd5, 1'b0);
    step(0, 0, 0, 0);
    check("rst_resel_s1", 12'd0, 1'b0, 4'd5, 1'b0);
    step(0, 0, 0, 0);
    check("rst_resel_out", 12'd15, 1'b1, 4'd5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
